// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store bus master.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  // Bit positions inside the one-hot MemSrcM {b,h,w,bu,hu}
  localparam int unsigned MS_B  = 4;
  localparam int unsigned MS_H  = 3;
  localparam int unsigned MS_W  = 2;
  localparam int unsigned MS_BU = 1;
  localparam int unsigned MS_HU = 0;

  // Access size encoding used internally
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    be_gen = 4'b0001 << off;
      SZ_H:    be_gen = 4'b0011 << off;
      default: be_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane replication / byte enables, load right-alignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_data
);

  // Replicate store data on all lanes, shift the read word down to bit 0
  always_comb begin
    be = be_gen(size, wr_off);
    case (size)
      SZ_B:    wr_lanes = {4{wr_data[7:0]}};
      SZ_H:    wr_lanes = {2{wr_data[15:0]}};
      default: wr_lanes = wr_data;
    endcase
    rd_data = rd_word >> {rd_off, 3'b000};
  end

endmodule

// File: rtl/lsu_mem_if.sv
// MEM-stage load/store bus master: one req/gnt/rvalid transaction per access,
// pipeline stalled until completion, load data returned right-aligned.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned accesses instead of
// forcing the offset down to an aligned address).
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [4:0]  MemSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

  lsu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     off_q, off_d;
  logic [1:0]     size;
  logic [1:0]     raw_off;
  logic [1:0]     eff_off;
  logic [3:0]     lane_be;
  logic [31:0]    lane_wdata;
  logic [31:0]    rd_shift;
  logic           req_d, we_d, buserr_d, mis_d;
  logic [31:0]    addr_d, wdata_d, rdata_d;
  logic [3:0]     be_d;

  assign raw_off = ALUResultM[1:0];

  // Decode access size from the one-hot source select
  always_comb begin
    size = SZ_B;
    if (MemSrcM[MS_W])                       size = SZ_W;
    else if (MemSrcM[MS_H] | MemSrcM[MS_HU]) size = SZ_H;
    else if (MemSrcM[MS_B] | MemSrcM[MS_BU]) size = SZ_B;
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == SZ_H) && (raw_off == 2'd3)) ||
                      ((size == SZ_W) && (raw_off != 2'd0));
  assign eff_off = raw_off;
`else
  // Force the offset down to the natural alignment of the access
  always_comb begin
    eff_off = raw_off;
    if (size == SZ_H) eff_off[0] = 1'b0;
    if (size == SZ_W) eff_off    = 2'b00;
  end
`endif

  lsu_align u_align (
    .size     (size),
    .wr_off   (eff_off),
    .wr_data  (WriteDataM),
    .rd_off   (off_q),
    .rd_word  (bus_rdata),
    .be       (lane_be),
    .wr_lanes (lane_wdata),
    .rd_data  (rd_shift)
  );

  // Pipeline freeze is combinational so it covers the presenting cycle
  assign StallM = MemReqM & (state_q != DONE);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    req_d    = bus_req;
    we_d     = bus_we;
    addr_d   = bus_addr;
    be_d     = bus_be;
    wdata_d  = bus_wdata;
    rdata_d  = ReadDataM;
    buserr_d = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = DONE;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else
`endif
          begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_wdata;
            off_d   = eff_off;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = WAIT_RSP;
          req_d   = 1'b0;
          cnt_d   = '0;
        end else if (!MemReqM) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_rvalid) begin
          state_d = DONE;
          if (!bus_we) rdata_d = rd_shift;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d  = DONE;
          rdata_d  = '0;
          buserr_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      MisalignM <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_be    <= be_d;
      bus_wdata <= wdata_d;
      ReadDataM <= rdata_d;
      BusErrM   <= buserr_d;
      MisalignM <= mis_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: vector table, scoreboard queue, bus responder.
module tb_lsu_mem_if;

  localparam int unsigned TO = 64;
  localparam logic [4:0] S_B  = 5'b10000;
  localparam logic [4:0] S_H  = 5'b01000;
  localparam logic [4:0] S_W  = 5'b00100;
  localparam logic [4:0] S_BU = 5'b00010;
  localparam logic [4:0] S_HU = 5'b00001;

  typedef struct {
    logic        we;
    logic [4:0]  src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          gnt_dly;
    logic        rv_en;
    logic        req;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        rd_chk;
    logic [31:0] rd;
    int          stall;
    logic        berr;
    logic        mis;
  } vec_t;

  logic        clk, rst;
  logic        MemReqM, MemWriteM;
  logic [4:0]  MemSrcM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          gnt_dly = 0;
  logic        rv_en = 1'b1;
  logic [31:0] rsp_data = '0;
  int          gnt_count = 0;
  vec_t        exp_q[$];
  vec_t        vecs[13];

  lsu_mem_if #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .MemSrcM(MemSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] src, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rsp, input int gd,
                              input logic rv, input logic req, input logic [3:0] be,
                              input logic [31:0] bwd, input logic rdc, input logic [31:0] rd,
                              input int stall, input logic berr, input logic mis);
    vec_t v;
    v.we = we; v.src = src; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
    v.gnt_dly = gd; v.rv_en = rv; v.req = req; v.be = be; v.bwd = bwd;
    v.rd_chk = rdc; v.rd = rd; v.stall = stall; v.berr = berr; v.mis = mis;
    return v;
  endfunction

  // Bus slave model: grant after gnt_dly request cycles, respond one cycle later
  initial begin
    bit granted;
    int req_wait;
    granted = 0; req_wait = 0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (rst) begin
        granted = 0; req_wait = 0;
      end else if (bus_req) begin
        granted = 0;
        if (req_wait >= gnt_dly) begin
          bus_gnt = 1'b1; granted = 1; req_wait = 0; gnt_count++;
        end else req_wait++;
      end else if (granted) begin
        req_wait = 0;
        if (rv_en) begin
          bus_rvalid = 1'b1; bus_rdata = rsp_data; granted = 0;
        end
      end else req_wait = 0;
    end
  end

  // Present one access, watch the bus every cycle, compare at DONE
  task automatic run(input vec_t v);
    vec_t e;
    int   stall_n;
    bit   seen, fin;
    logic [31:0] ea;
    gnt_dly = v.gnt_dly; rv_en = v.rv_en; rsp_data = v.rsp;
    exp_q.push_back(v);
    @(posedge clk); #1;
    MemReqM = 1'b1; MemWriteM = v.we; MemSrcM = v.src;
    ALUResultM = v.addr; WriteDataM = v.wdata;
    ea = v.addr & 32'hFFFF_FFFC;
    stall_n = 0; seen = 0; fin = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!StallM) begin fin = 1; break; end
      stall_n++;
      if (bus_req) begin
        seen = 1;
        chk("bus_addr", bus_addr, ea);
        chk("bus_be", 32'(bus_be), 32'(v.be));
        chk("bus_we", 32'(bus_we), 32'(v.we));
        if (v.we) chk("bus_wdata", bus_wdata, v.bwd);
      end
      @(posedge clk); #1;
    end
    MemReqM = 1'b0;
    e = exp_q.pop_front();
    chk("done_reached", 32'(fin), 32'd1);
    chk("req_seen", 32'(seen), 32'(e.req));
    chk("stall_cycles", 32'(stall_n), 32'(e.stall));
    chk("buserr_pulse", 32'(BusErrM), 32'(e.berr));
    chk("misalign_pulse", 32'(MisalignM), 32'(e.mis));
    if (e.rd_chk) chk("read_data", ReadDataM, e.rd);
    @(posedge clk); #2;
    chk("pulses_clear", 32'({BusErrM, MisalignM}), 32'd0);
  endtask

  initial begin
    int g0;
    rst = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; MemSrcM = '0;
    ALUResultM = '0; WriteDataM = '0;

    //            we src   addr          wdata         rsp           gd rv req be       bwd           rdc rd            st  be mi
    vecs[0]  = mk(0, S_W,  32'h100, 32'h0,         32'hDEADBEEF, 0, 1, 1, 4'b1111, 32'h0,         1, 32'hDEADBEEF, 3, 0, 0);
    vecs[1]  = mk(0, S_BU, 32'h103, 32'h0,         32'h8899AABB, 0, 1, 1, 4'b1000, 32'h0,         1, 32'h00000088, 3, 0, 0);
    vecs[2]  = mk(1, S_H,  32'h202, 32'h1234ABCD,  32'h0,        0, 1, 1, 4'b1100, 32'hABCDABCD,  1, 32'h00000088, 3, 0, 0);
    vecs[3]  = mk(0, S_W,  32'h104, 32'h0,         32'h11223344, 5, 1, 1, 4'b1111, 32'h0,         1, 32'h11223344, 8, 0, 0);
    vecs[4]  = mk(0, S_H,  32'h102, 32'h0,         32'hCAFEF00D, 0, 1, 1, 4'b1100, 32'h0,         1, 32'h0000CAFE, 3, 0, 0);
    vecs[5]  = mk(1, S_B,  32'h305, 32'h000000A5,  32'h0,        0, 1, 1, 4'b0010, 32'hA5A5A5A5,  1, 32'h0000CAFE, 3, 0, 0);
    vecs[6]  = mk(1, S_W,  32'h400, 32'h01020304,  32'h0,        1, 1, 1, 4'b1111, 32'h01020304,  1, 32'h0000CAFE, 4, 0, 0);
    vecs[7]  = mk(0, S_B,  32'h101, 32'h0,         32'h00003300, 0, 1, 1, 4'b0010, 32'h0,         1, 32'h00000033, 3, 0, 0);
    vecs[8]  = mk(0, S_W,  32'h500, 32'h0,         32'h12345678, 0, 0, 1, 4'b1111, 32'h0,         1, 32'h0,        TO+2, 1, 0);
`ifdef MISALIGN_TRAP_EN
    vecs[9]  = mk(0, S_W,  32'h101, 32'h0,         32'h55667788, 0, 1, 0, 4'b1111, 32'h0,         1, 32'h0,         1, 0, 1);
    vecs[10] = mk(1, S_H,  32'h203, 32'h0000BEEF,  32'h0,        0, 1, 0, 4'b1100, 32'hBEEFBEEF,  1, 32'h0,         1, 0, 1);
    vecs[11] = mk(0, S_HU, 32'h201, 32'h0,         32'h00ABCD00, 0, 1, 1, 4'b0110, 32'h0,         1, 32'h0000ABCD, 3, 0, 0);
`else
    vecs[9]  = mk(0, S_W,  32'h101, 32'h0,         32'h55667788, 0, 1, 1, 4'b1111, 32'h0,         1, 32'h55667788, 3, 0, 0);
    vecs[10] = mk(1, S_H,  32'h203, 32'h0000BEEF,  32'h0,        0, 1, 1, 4'b1100, 32'hBEEFBEEF,  1, 32'h55667788, 3, 0, 0);
    vecs[11] = mk(0, S_HU, 32'h201, 32'h0,         32'h00ABCD00, 0, 1, 1, 4'b0011, 32'h0,         1, 32'h00ABCD00, 3, 0, 0);
`endif
    vecs[12] = mk(0, S_W,  32'h0FC, 32'h0,         32'hF00DF00D, 2, 1, 1, 4'b1111, 32'h0,         1, 32'hF00DF00D, 5, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", ReadDataM, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_flags", 32'({StallM, MisalignM, BusErrM}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run(vecs[i]);

    // Flush while grant is withheld: back to IDLE, no grant consumed
    gnt_dly = 1000; rv_en = 1'b1; g0 = gnt_count;
    @(posedge clk); #1;
    MemReqM = 1'b1; MemWriteM = 1'b0; MemSrcM = S_W; ALUResultM = 32'h600;
    repeat (3) begin
      @(posedge clk); #2;
      chk("flush_req_held", 32'(bus_req), 32'd1);
      chk("flush_addr_held", bus_addr, 32'h600);
      chk("flush_stall", 32'(StallM), 32'd1);
    end
    MemReqM = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("flush_idle_req", 32'(bus_req), 32'd0);
      chk("flush_idle_stall", 32'(StallM), 32'd0);
    end
    chk("flush_no_gnt", 32'(gnt_count - g0), 32'd0);

    // Reset during WAIT_RSP: bus_req and outputs cleared at once
    gnt_dly = 0; rv_en = 1'b0;
    @(posedge clk); #1;
    MemReqM = 1'b1; MemSrcM = S_W; ALUResultM = 32'h700;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_readdata", ReadDataM, 32'h0);
    MemReqM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("midrst_idle", 32'({bus_req, StallM, BusErrM}), 32'd0);
    end

    // Recovery after reset
    run(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
